// File: rtl/snake_renderer.sv
// Pixel colour stage: 40x30 cell map with clear FSM; optional grid overlay under SNAKE_GRID_LINES_EN.
// Latency: 2 pix_en ticks from h/v/sync sample to R/G/B/HS/VS; frame_tick 1 clk after its tick.
// No backpressure: pix_en ticks must be at least 2 clks apart; the map read completes on the clk after each tick.
module snake_renderer #(
  parameter int CELL_SHIFT = 4,
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_en,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       video_on,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       clr_req,
  input  logic       wr_en,
  input  logic [5:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [1:0] wr_cell,
  output logic [3:0] R,
  output logic [3:0] G,
  output logic [3:0] B,
  output logic       HS,
  output logic       VS,
  output logic       busy,
  output logic       frame_tick
);

  localparam int          NCELL     = GRID_W * GRID_H;
  localparam logic [15:0] NCELL_W   = 16'(NCELL);
  localparam logic [10:0] LAST_ADDR = 11'(NCELL - 1);
  localparam logic [5:0]  GRID_W6   = 6'(GRID_W);
  localparam logic [4:0]  GRID_H5   = 5'(GRID_H);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]  state;
  logic [10:0] clr_addr;
  logic [1:0]  mem [0:NCELL-1];
  logic [1:0]  rd_dat;

  logic        wr_ok;
  logic [10:0] wr_addr;
  logic        mem_we;
  logic [10:0] mem_wa;
  logic [1:0]  mem_wd;

  logic [9:0]  hc, vc;
  logic [15:0] rd_lin;

  logic        pe_d;
  logic [10:0] s1_addr;
  logic        s1_von, s1_hs, s1_vs;
`ifdef SNAKE_GRID_LINES_EN
  logic [CELL_SHIFT-1:0] s1_hoff, s1_voff;
`endif
  logic [11:0] pix_rgb;

  assign busy = (state == CLEAR);

  // y*40 + x as two shifts and adds
  assign wr_addr = {1'b0, wr_y, 5'b0} + {3'b0, wr_y, 3'b0} + {5'b0, wr_x};
  assign wr_ok   = (state == RUN) && wr_en && (wr_x < GRID_W6) && (wr_y < GRID_H5);

  // A restart request inside CLEAR wipes address 0 on the same clk
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_addr;
    mem_wd = wr_cell;
    if (state == CLEAR) begin
      mem_we = reset_n;
      mem_wa = clr_req ? 11'd0 : clr_addr;
      mem_wd = 2'd0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_addr <= 11'd0;
    end else if (clr_req) begin
      clr_addr <= (state == RUN) ? 11'd0 : 11'd1;
      state    <= CLEAR;
    end else if (state == CLEAR) begin
      if (clr_addr == LAST_ADDR) begin
        state    <= RUN;
        clr_addr <= 11'd0;
      end else begin
        clr_addr <= clr_addr + 11'd1;
      end
    end
  end

  assign hc     = h_count >> CELL_SHIFT;
  assign vc     = v_count >> CELL_SHIFT;
  assign rd_lin = ({6'b0, vc} << 5) + ({6'b0, vc} << 3) + {6'b0, hc};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pe_d    <= 1'b0;
      s1_addr <= 11'd0;
      s1_von  <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
`ifdef SNAKE_GRID_LINES_EN
      s1_hoff <= '0;
      s1_voff <= '0;
`endif
    end else begin
      pe_d <= pix_en;
      if (pix_en) begin
        s1_addr <= (rd_lin < NCELL_W) ? rd_lin[10:0] : 11'd0;
        s1_von  <= video_on;
        s1_hs   <= hs_in;
        s1_vs   <= vs_in;
`ifdef SNAKE_GRID_LINES_EN
        s1_hoff <= h_count[CELL_SHIFT-1:0];
        s1_voff <= v_count[CELL_SHIFT-1:0];
`endif
      end
    end
  end

  // Map storage: read-before-write, read snapshot taken the clk after each tick
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
    if (pe_d)
      rd_dat <= mem[s1_addr];
  end

  always_comb begin
    pix_rgb = 12'h000;
    case (rd_dat)
      2'd1:    pix_rgb = 12'h0C0;
      2'd2:    pix_rgb = 12'h0F4;
      2'd3:    pix_rgb = 12'hF00;
      default: pix_rgb = 12'h000;
    endcase
`ifdef SNAKE_GRID_LINES_EN
    if ((s1_hoff == '0 || s1_voff == '0) && rd_dat != 2'd3)
      pix_rgb = 12'h222;
`endif
    if (!s1_von || busy)
      pix_rgb = 12'h000;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      R          <= 4'h0;
      G          <= 4'h0;
      B          <= 4'h0;
      HS         <= 1'b1;
      VS         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en && (v_count == 10'd480) && (h_count == 10'd0);
      if (pix_en) begin
        {R, G, B} <= pix_rgb;
        HS        <= s1_hs;
        VS        <= s1_vs;
      end
    end
  end

endmodule

// File: tb/tb_snake_renderer.sv
// Bench for snake_renderer: directed steps plus random writes/pixels checked against a cell-grid model.
module tb_snake_renderer;

  logic       clk = 1'b0;
  logic       reset_n, pix_en, video_on, hs_in, vs_in, clr_req, wr_en;
  logic [9:0] h_count, v_count;
  logic [5:0] wr_x;
  logic [4:0] wr_y;
  logic [1:0] wr_cell;
  logic [3:0] R, G, B;
  logic       HS, VS, busy, frame_tick;

  always #5 clk = ~clk;

  snake_renderer dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .h_count(h_count), .v_count(v_count),
    .video_on(video_on), .hs_in(hs_in), .vs_in(vs_in), .clr_req(clr_req), .wr_en(wr_en),
    .wr_x(wr_x), .wr_y(wr_y), .wr_cell(wr_cell), .R(R), .G(G), .B(B), .HS(HS), .VS(VS),
    .busy(busy), .frame_tick(frame_tick)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0]  cells [0:39][0:29];
  bit          chk_pix;
  logic [13:0] cur_e, pend_e;   // {rgb, hs, vs} now on the outputs / waiting in the pipeline

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] mpix(int h, int v, bit von, bit hs, bit vs);
    logic [11:0] c;
    logic [1:0]  code;
    c = 12'h000;
    if (von) begin
      code = cells[h / 16][v / 16];
      case (code)
        2'd1:    c = 12'h0C0;
        2'd2:    c = 12'h0F4;
        2'd3:    c = 12'hF00;
        default: c = 12'h000;
      endcase
`ifdef SNAKE_GRID_LINES_EN
      if (code != 2'd3 && (h % 16 == 0 || v % 16 == 0))
        c = 12'h222;
`endif
    end
    return {c, hs, vs};
  endfunction

  task automatic clear_model();
    for (int x = 0; x < 40; x++)
      for (int y = 0; y < 30; y++)
        cells[x][y] = 2'd0;
  endtask

  // One clock with inputs as currently driven; checks pixel outputs and frame_tick
  task automatic cyc(input bit pe);
    logic [13:0] np;
    bit          fe;
    pix_en = pe;
    fe = pe && reset_n && v_count == 10'd480 && h_count == 10'd0;
    np = mpix(int'(h_count), int'(v_count), video_on, hs_in, vs_in);
    @(posedge clk);
    @(negedge clk);
    pix_en = 1'b0;
    if (pe && reset_n) begin
      cur_e  = pend_e;
      pend_e = np;
    end
    if (chk_pix) chk("pixel", {R, G, B, HS, VS}, cur_e);
    chk("frame_tick", frame_tick, fe);
  endtask

  task automatic px(input int h, input int v, input bit von, input bit hs, input bit vs);
    h_count = 10'(h); v_count = 10'(v); video_on = von; hs_in = hs; vs_in = vs;
    cyc(1'b1);
    repeat ($urandom_range(1, 2)) begin
      h_count = 10'($urandom_range(1, 1023));
      hs_in   = 1'($urandom);
      cyc(1'b0);
    end
  endtask

  task automatic wr(input int x, input int y, input int c);
    wr_en = 1'b1; wr_x = 6'(x); wr_y = 5'(y); wr_cell = 2'(c);
    cyc(1'b0);
    wr_en = 1'b0;
    if (x < 40 && y < 30) cells[x][y] = 2'(c);
  endtask

  task automatic scan_all();
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++)
        px(x * 16 + 8, y * 16 + 8, 1'b1, 1'b1, 1'b1);
  endtask

  // Entered on a negedge with busy already high; counts busy clks, optionally re-requesting a clear
  task automatic run_clear(input int restart_at, input int exp_len, input string tag);
    int n = 0;
    chk_pix = 1'b0;
    clear_model();
    while (busy === 1'b1 && n < 5000) begin
      clr_req  = (n == restart_at);
      h_count  = 10'($urandom_range(0, 639));
      v_count  = 10'($urandom_range(0, 479));
      video_on = 1'b1;
      cyc(n % 2 == 0);
      clr_req = 1'b0;
      if (n % 2 == 0) chk("busy_blank", {R, G, B}, 12'h000);
      n++;
    end
    chk(tag, n, exp_len);
    repeat (2) begin
      video_on = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
      cyc(1'b1);
      cyc(1'b0);
    end
    chk_pix = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    chk_pix = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk("rst_rgb", {R, G, B}, 12'h000);
    chk("rst_hs", HS, 1'b1);
    chk("rst_vs", VS, 1'b1);
    chk("rst_busy", busy, 1'b1);
    cur_e  = 14'h0003;
    pend_e = 14'h0003;
    reset_n = 1'b1;
    run_clear(-1, 1200, "busy_len_reset");
  endtask

  initial begin
    reset_n = 1'b0; pix_en = 1'b0; video_on = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    clr_req = 1'b0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_cell = '0;
    h_count = '0; v_count = '0;
    chk_pix = 1'b0;
    cur_e = 14'h0003; pend_e = 14'h0003;
    clear_model();

    do_reset();
    scan_all();

    // head at (2,1) and the pixels around it
    wr(2, 1, 2);
    for (int v = 15; v <= 17; v++)
      for (int h = 28; h <= 50; h++)
        px(h, v, 1'b1, 1'b1, 1'b1);

    // food with video_on low, plus an hs pulse
    wr(5, 5, 3);
    px(83, 83, 1'b1, 1'b1, 1'b1);
    px(83, 83, 1'b0, 1'b0, 1'b1);
    px(83, 83, 1'b1, 1'b1, 1'b0);
    px(84, 84, 1'b1, 1'b1, 1'b1);
    px(84, 84, 1'b1, 1'b1, 1'b1);

    // out-of-range writes must not touch the map
    wr(40, 3, 1);
    wr(63, 3, 1);
    wr(3, 30, 1);
    wr(0, 31, 2);
    for (int x = 0; x < 40; x++) px(x * 16 + 8, 3 * 16 + 8, 1'b1, 1'b1, 1'b1);
    for (int x = 0; x < 4; x++) px(x * 16 + 8, 0 * 16 + 8, 1'b1, 1'b1, 1'b1);

    // random writes and pixels
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr($urandom_range(0, 45), $urandom_range(0, 33), $urandom_range(0, 3));
      end else begin
        int h, v;
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
        px(h, v, (h < 640 && v < 480), 1'($urandom), 1'($urandom));
      end
    end

    // frame_tick only at v=480, h=0 with pix_en
    px(0, 480, 1'b0, 1'b1, 1'b1);
    px(1, 480, 1'b0, 1'b1, 1'b1);
    px(0, 481, 1'b0, 1'b1, 1'b1);
    px(0, 479, 1'b1, 1'b1, 1'b1);
    h_count = 10'd0; v_count = 10'd480; video_on = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    px(0, 480, 1'b0, 1'b1, 0);

    // re-clear from RUN, restarted at clear address 500
    for (int i = 0; i < 10; i++) wr(i * 3, i * 2, (i % 3) + 1);
    clr_req = 1'b1;
    cyc(1'b0);
    clr_req = 1'b0;
    run_clear(500, 1700, "busy_len_restart");
    scan_all();

    // reset mid-frame while food is on screen
    wr(10, 10, 3);
    px(168, 168, 1'b1, 1'b1, 1'b1);
    px(168, 168, 1'b1, 1'b1, 1'b1);
    chk("food_shown", {R, G, B}, 12'hF00);
    do_reset();

    // reset mid-clear
    wr(7, 7, 1);
    clr_req = 1'b1;
    cyc(1'b0);
    clr_req = 1'b0;
    repeat (300) cyc(1'b0);
    do_reset();
    for (int x = 0; x < 40; x++) px(x * 16 + 8, 7 * 16 + 8, 1'b1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_renderer.md
# snake_renderer

Pixel-colour stage that sits directly downstream of the VGA timing chain: it consumes the pixel counters and raw sync signals and produces the registered 12-bit RGB and aligned HS/VS that drive the connector. It owns a 40×30 cell map, 16×16 pixels per cell, written by the game logic. Each visible pixel is translated to its cell and coloured by cell type. A clear state machine wipes the map after reset or on request.

## Interface
- CELL_SHIFT, 4: log2 of cell size in pixels.
- GRID_W, 40: cells per row.
- GRID_H, 30: cells per column.
- clk  in  1  system clock (100 MHz); all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- pix_en  in  1  one-clk pixel tick (25 MHz rate); pipeline advances only when high.
- h_count  in  10  horizontal pixel counter from timing chain.
- v_count  in  10  vertical line counter from timing chain.
- video_on  in  1  high inside the 640×480 visible area.
- hs_in, vs_in  in  1 each  raw syncs from timing chain.
- clr_req  in  1  one-clk request to re-clear the map.
- wr_en  in  1  cell write strobe.
- wr_x  in  6  cell column, 0..GRID_W-1.
- wr_y  in  5  cell row, 0..GRID_H-1.
- wr_cell  in  2  cell code: 0 empty, 1 body, 2 head, 3 food.
- R, G, B  out  4 each  pixel colour.
- HS, VS  out  1 each  syncs delayed to match RGB.
- busy  out  1  high while clearing.
- frame_tick  out  1  one-clk pulse at start of vertical blanking.

## Operation
- Cell map: GRID_W×GRID_H entries × 2 bits, linear address = y*40 + x, computed as (y<<5)+(y<<3)+x, 11 bits.
- Storage: one write port and one registered read port; no reset of contents.
- Write rules:
  - wr_en with wr_x ≥ GRID_W or wr_y ≥ GRID_H is ignored.
  - Read and write to the same address in the same clk returns the old data.
- FSM states: CLEAR, RUN.
  - reset_n low → CLEAR, clear address 0.
  - CLEAR: writes 0 to one address per clk, 0..1199; after address 1199 → RUN; busy high for exactly 1200 clks.
  - RUN: wr_en honoured; clr_req → CLEAR at address 0.
  - clr_req during CLEAR restarts at address 0.
  - wr_en ignored in CLEAR.
- Pixel pipeline, each stage enabled by pix_en:
  - S1: register address = (v_count>>4)*40 + (h_count>>4), in-cell offsets h[3:0]/v[3:0], video_on, hs_in, vs_in.
  - S2: register the cell read and delayed controls; drive R/G/B/HS/VS.
- Colour map:
  - empty 0x000.
  - body 0x0C0.
  - head 0x0F4.
  - food 0xF00.
  - Any pixel with delayed video_on low, or busy high, outputs 0x000.
- frame_tick: pulses on the clk where pix_en is high and inputs show v_count==480 and h_count==0.

## Timing
- Reset values:
  - R/G/B = 0.
  - HS = VS = 1.
  - busy = 1, starting the clk after reset_n is sampled low.
  - frame_tick = 0.
  - Pipeline registers cleared with video_on = 0 and syncs = 1.
- Latency: exactly 2 pix_en ticks from input sample to R/G/B/HS/VS. Syncs and colour stay aligned to the same pixel.
- Outputs hold between pix_en ticks.
- A cell write is visible to a pixel read from S1 at the following pix_en tick or later.
- Reset asserted mid-clear or mid-frame: FSM restarts CLEAR at 0 and the pipeline is flushed on that edge.

## Configuration
- SNAKE_GRID_LINES_EN defined: pixels with in-cell offset h==0 or v==0 in the visible area render 0x222 regardless of cell code. Exception: food, which keeps 0xF00. Busy blanking still overrides.
- Undefined: no grid lines; colour depends on cell code only.

## Test plan
- Reset then release → busy high 1200 clks, then low. RGB 0x000 throughout. Reading any cell returns 0.
- Write (x=2, y=1, head), then sweep h=32..47, v=16 with pix_en → R/G/B = 0x0F4 two pix_en ticks after each of those pixels. Neighbouring pixels give 0x000, or 0x222 on grid lines with SNAKE_GRID_LINES_EN.
- Drive video_on low with a cell holding food (3) → RGB 0x000. hs_in pulse appears on HS exactly 2 pix_en ticks later.
- Write wr_x=40 with code 1, then scan the whole row → no cell changes.
- clr_req in RUN after filling cells; then clr_req again at clear address 500 → busy high for 500+1200 clks total, all cells 0 afterward.
- Step v_count to 480 and h_count to 0 with pix_en → frame_tick high for exactly one clk; no pulse at any other count.
